// File: rtl/pu_accum_ctrl_pkg.sv
// ============================================================================
// Module  : pu_accum_ctrl_pkg
// Brief   : Shared types for the accumulator-PU sequencer (states, FIFO entry).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pu_accum_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_GAP  = 3'd2,
    ST_REQ  = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ATTR_W = 4;
  localparam int ENTRY_W    = DEF_DATA_W + DEF_ATTR_W + 2;

  // Buffered operand layout, MSB first: {last, neg, attr, data}
  typedef struct packed {
    logic                  last;
    logic                  neg;
    logic [DEF_ATTR_W-1:0] attr;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

  function automatic int entry_width(input int dw, input int aw);
    return dw + aw + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pu_accum_ctrl_fifo.sv
// ============================================================================
// Module  : pu_accum_ctrl_fifo
// Brief   : Synchronous operand FIFO with full/empty flags, no pass-through.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pu_accum_ctrl_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer bit distinguishes full from empty when indices coincide
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign rdata = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/pu_accum_ctrl.sv
// ============================================================================
// Module  : pu_accum_ctrl
// Brief   : Operand sequencer for one accumulator PU: buffers operands, paces
//           load/init/neg strobes, arbitrates the output bus and pulses oe.
//           Optional group/overflow counters with PU_ACCUM_CTRL_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pu_accum_ctrl
  import pu_accum_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ATTR_WIDTH = 4,
  parameter int OVERFLOW   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ATTR_WIDTH-1:0] in_attr,
  input  logic                  in_neg,
  input  logic                  in_last,
  output logic                  signal_load,
  output logic                  signal_init,
  output logic                  signal_neg,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [ATTR_WIDTH-1:0] attr_in,
  output logic                  signal_oe,
  output logic                  out_req,
  input  logic                  out_grant,
  output logic                  res_valid,
`ifdef PU_ACCUM_CTRL_STATS_EN
  input  logic [ATTR_WIDTH-1:0] pu_attr_out,
  output logic [15:0]           grp_count,
  output logic [15:0]           ovf_count,
`endif
  output logic                  busy
);

  localparam int EW = entry_width(DATA_WIDTH, ATTR_WIDTH);

  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [EW-1:0] fifo_wdata, fifo_rdata;

  state_t                state_q, state_d;
  logic                  first_pending_q, first_pending_d;
  logic                  ld_init_q, ld_init_d;
  logic                  ld_neg_q, ld_neg_d;
  logic                  ld_last_q, ld_last_d;
  logic [DATA_WIDTH-1:0] ld_data_q, ld_data_d;
  logic [ATTR_WIDTH-1:0] ld_attr_q, ld_attr_d;

  assign in_ready   = !fifo_full;
  assign fifo_push  = in_valid && !fifo_full;
  assign fifo_wdata = {in_last, in_neg, in_attr, in_data};

  pu_accum_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      first_pending_q <= 1'b1;
      ld_init_q       <= 1'b0;
      ld_neg_q        <= 1'b0;
      ld_last_q       <= 1'b0;
      ld_data_q       <= '0;
      ld_attr_q       <= '0;
    end else begin
      state_q         <= state_d;
      first_pending_q <= first_pending_d;
      ld_init_q       <= ld_init_d;
      ld_neg_q        <= ld_neg_d;
      ld_last_q       <= ld_last_d;
      ld_data_q       <= ld_data_d;
      ld_attr_q       <= ld_attr_d;
    end
  end

  // The head word is captured on the pop edge so LOAD drives it from flops
  always_comb begin
    state_d         = state_q;
    fifo_pop        = 1'b0;
    first_pending_d = first_pending_q;
    ld_init_d       = ld_init_q;
    ld_neg_d        = ld_neg_q;
    ld_last_d       = ld_last_q;
    ld_data_d       = ld_data_q;
    ld_attr_d       = ld_attr_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) fifo_pop = 1'b1;
      ST_LOAD: state_d = ST_GAP;
      ST_GAP: begin
        if (ld_last_q)        state_d = ST_REQ;
        else if (!fifo_empty) fifo_pop = 1'b1;
        else                  state_d = ST_IDLE;
      end
      ST_REQ: if (out_grant) state_d = ST_OUT;
      ST_OUT: begin
        if (!fifo_empty) fifo_pop = 1'b1;
        else             state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (fifo_pop) begin
      state_d         = ST_LOAD;
      ld_data_d       = fifo_rdata[DATA_WIDTH-1:0];
      ld_attr_d       = fifo_rdata[DATA_WIDTH +: ATTR_WIDTH];
      ld_neg_d        = fifo_rdata[EW-2];
      ld_last_d       = fifo_rdata[EW-1];
      ld_init_d       = first_pending_q;
      first_pending_d = fifo_rdata[EW-1];
    end
  end

  always_comb begin
    signal_load = (state_q == ST_LOAD);
    signal_init = signal_load && ld_init_q;
    signal_neg  = signal_load && ld_neg_q;
    data_in     = signal_load ? ld_data_q : '0;
    attr_in     = signal_load ? ld_attr_q : '0;
    out_req     = (state_q == ST_REQ);
    signal_oe   = out_req && out_grant;
    res_valid   = (state_q == ST_OUT);
    busy        = (state_q != ST_IDLE) || !fifo_empty;
  end

`ifdef PU_ACCUM_CTRL_STATS_EN
  logic [15:0] grp_count_q, grp_count_d;
  logic [15:0] ovf_count_q, ovf_count_d;
  logic        ovf_hit;

  assign ovf_hit = |(pu_attr_out & (ATTR_WIDTH'(1) << OVERFLOW));

  always_comb begin
    grp_count_d = grp_count_q;
    ovf_count_d = ovf_count_q;
    if (res_valid) begin
      if (grp_count_q != 16'hFFFF)            grp_count_d = grp_count_q + 16'd1;
      if (ovf_hit && ovf_count_q != 16'hFFFF) ovf_count_d = ovf_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp_count_q <= '0;
      ovf_count_q <= '0;
    end else begin
      grp_count_q <= grp_count_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign grp_count = grp_count_q;
  assign ovf_count = ovf_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pu_accum_ctrl.sv
// ============================================================================
// Module  : tb_pu_accum_ctrl
// Brief   : Self-checking bench for pu_accum_ctrl (cycle model + directed cases).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pu_accum_ctrl;

  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int OVF   = 1;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] in_attr = '0;
  logic          in_neg = 1'b0;
  logic          in_last = 1'b0;
  logic          signal_load, signal_init, signal_neg, signal_oe;
  logic [DW-1:0] data_in;
  logic [AW-1:0] attr_in;
  logic          out_req, res_valid, busy;
  logic          out_grant = 1'b1;
`ifdef PU_ACCUM_CTRL_STATS_EN
  logic          ovf_sel = 1'b0;
  logic [AW-1:0] pu_attr_out;
  logic [15:0]   grp_count, ovf_count;
  assign pu_attr_out = ovf_sel ? 4'b0010 : 4'b0000;
`endif

  always #5 clk = ~clk;

  pu_accum_ctrl #(
    .DATA_WIDTH (DW), .ATTR_WIDTH (AW), .OVERFLOW (OVF), .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
    .in_attr (in_attr), .in_neg (in_neg), .in_last (in_last),
    .signal_load (signal_load), .signal_init (signal_init), .signal_neg (signal_neg),
    .data_in (data_in), .attr_in (attr_in), .signal_oe (signal_oe),
    .out_req (out_req), .out_grant (out_grant), .res_valid (res_valid),
`ifdef PU_ACCUM_CTRL_STATS_EN
    .pu_attr_out (pu_attr_out), .grp_count (grp_count), .ovf_count (ovf_count),
`endif
    .busy (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_LOAD = 1, M_GAP = 2, M_REQ = 3, M_OUT = 4;
  logic [9:0] mq[$];         // {last, neg, attr, data}
  int         m_mode    = M_IDLE;
  logic [9:0] m_ld      = '0;
  bit         m_ld_init = 1'b0;
  bit         m_first   = 1'b1;

  always @(posedge clk or posedge rst) begin
    bit take, can_pop, do_push;
    logic [9:0] w;
    if (rst) begin
      mq.delete();
      m_mode = M_IDLE; m_first = 1'b1; m_ld = '0; m_ld_init = 1'b0;
    end else begin
      do_push = in_valid && (mq.size() < DEPTH);
      w       = {in_last, in_neg, in_attr, in_data};
      can_pop = (mq.size() > 0);
      take    = 1'b0;
      case (m_mode)
        M_IDLE: take = can_pop;
        M_LOAD: m_mode = M_GAP;
        M_GAP:  if (m_ld[9]) m_mode = M_REQ; else if (can_pop) take = 1'b1; else m_mode = M_IDLE;
        M_REQ:  if (out_grant) m_mode = M_OUT;
        default: if (can_pop) take = 1'b1; else m_mode = M_IDLE;
      endcase
      if (take) begin
        m_ld = mq.pop_front(); m_ld_init = m_first; m_first = m_ld[9]; m_mode = M_LOAD;
      end
      if (do_push) mq.push_back(w);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- per-cycle compare + event log ----------------
  int         load_cyc[$], oe_cyc[$], rv_cyc[$];
  logic [9:0] load_word[$];  // {init, neg, attr, data}
  int         req_wait = 0;

  always @(negedge clk) begin
    bit e_load;
    if (chk_on) begin
      e_load = (m_mode == M_LOAD);
      chk("load",  signal_load, e_load);
      chk("init",  signal_init, e_load && m_ld_init);
      chk("neg",   signal_neg,  e_load && m_ld[8]);
      chk("data",  data_in,     e_load ? m_ld[3:0] : 4'h0);
      chk("attr",  attr_in,     e_load ? m_ld[7:4] : 4'h0);
      chk("req",   out_req,     m_mode == M_REQ);
      chk("oe",    signal_oe,   (m_mode == M_REQ) && out_grant);
      chk("rv",    res_valid,   m_mode == M_OUT);
      chk("ready", in_ready,    mq.size() < DEPTH);
      chk("busy",  busy,        (m_mode != M_IDLE) || (mq.size() > 0));
    end
    if (signal_load) begin
      load_cyc.push_back(cyc);
      load_word.push_back({signal_init, signal_neg, attr_in, data_in});
    end
    if (signal_oe) oe_cyc.push_back(cyc);
    if (res_valid) rv_cyc.push_back(cyc);
    if (out_req && !signal_oe) req_wait++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_logs();
    load_cyc.delete(); load_word.delete(); oe_cyc.delete(); rv_cyc.delete(); req_wait = 0;
  endtask

  task automatic send(input logic [3:0] d, input logic [3:0] a, input logic n, input logic l);
    in_valid = 1'b1; in_data = d; in_attr = a; in_neg = n; in_last = l;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_chk++;
    $display("FAIL send_timeout: got in_ready=0 for 100 cycles expected accept");
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) begin
        @(posedge clk); #1;
        return;
      end
    end
    n_chk++;
    $display("FAIL idle_timeout: got busy=1 for 200 cycles expected 0");
  endtask

  task automatic wait_sig(input int which);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ((which == 0 && out_req) || (which == 1 && signal_load)) return;
    end
    n_chk++;
    $display("FAIL wait_timeout: got no event %0d in 100 cycles expected one", which);
  endtask

  task automatic chk_words(input string name, input logic [9:0] exp[$]);
    chk({name, "_count"}, load_word.size(), exp.size());
    if (load_word.size() == exp.size())
      foreach (exp[i]) chk(name, load_word[i], exp[i]);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", in_ready, 1); chk("reset_busy", busy, 0);
    chk("reset_load", signal_load, 0); chk("reset_req", out_req, 0);
    rst = 1'b0;
    chk_on = 1'b1;

    // 1: three-operand group, grant tied high
    clear_logs(); out_grant = 1'b1;
    send(4'd3, 4'h0, 0, 0); send(4'd5, 4'h0, 0, 0); send(4'd2, 4'h0, 0, 1);
    wait_idle();
    chk_words("t1_word", '{10'h203, 10'h005, 10'h002});
    if (load_cyc.size() == 3 && oe_cyc.size() == 1 && rv_cyc.size() == 1) begin
      chk("t1_gap1", load_cyc[1] - load_cyc[0], 2);
      chk("t1_gap2", load_cyc[2] - load_cyc[0], 4);
      chk("t1_oe",   oe_cyc[0] - load_cyc[0], 6);
      chk("t1_rv",   rv_cyc[0] - load_cyc[0], 7);
    end else chk("t1_events", oe_cyc.size() + rv_cyc.size(), 2);

    // 2: subtracting last operand, attrs pass through
    clear_logs();
    send(4'd7, 4'hA, 0, 0); send(4'd2, 4'h3, 1, 1);
    wait_idle();
    chk_words("t2_word", '{10'h2A7, 10'h132});
    chk("t2_oe_count", oe_cyc.size(), 1);

    // 3: fill FIFO while stalled in REQ
    clear_logs(); out_grant = 1'b0;
    send(4'd9, 4'h0, 0, 1);
    send(4'd1, 4'h0, 0, 0); send(4'd2, 4'h0, 0, 0);
    send(4'd3, 4'h0, 0, 0); send(4'd4, 4'h0, 0, 1);
    @(negedge clk);
    chk("t3_full_ready", in_ready, 0);
    chk("t3_full_busy", busy, 1);
    @(posedge clk); #1;
    out_grant = 1'b1;
    send(4'd5, 4'h0, 0, 1);
    wait_idle();
    chk_words("t3_word", '{10'h209, 10'h201, 10'h002, 10'h003, 10'h004, 10'h205});
    chk("t3_oe_count", oe_cyc.size(), 3);

    // 4: grant withheld 5 cycles; push+pop at count 2 during OUT
    clear_logs(); out_grant = 1'b0;
    send(4'd6, 4'h0, 0, 1); send(4'd1, 4'h0, 0, 0); send(4'd8, 4'h0, 1, 1);
    wait_sig(0);
    repeat (5) @(posedge clk);
    #1 out_grant = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 4'd3; in_attr = 4'h0; in_neg = 1'b0; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();
    chk("t4_req_wait", req_wait, 5);
    chk_words("t4_word", '{10'h206, 10'h201, 10'h108, 10'h203});
    chk("t4_oe_count", oe_cyc.size(), 3);
    if (oe_cyc.size() > 0 && rv_cyc.size() > 0) chk("t4_rv_after_oe", rv_cyc[0] - oe_cyc[0], 1);

    // 5: async reset during GAP of an open group
    clear_logs(); out_grant = 1'b1;
    send(4'd6, 4'h0, 0, 0);
    wait_sig(1);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("t5_load", signal_load, 0); chk("t5_busy", busy, 0);
    chk("t5_ready", in_ready, 1);   chk("t5_data", data_in, 0);
    chk("t5_oe_none", oe_cyc.size(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    send(4'd4, 4'h0, 1, 1);
    wait_idle();
    chk_words("t5_word", '{10'h304});
    chk("t5_rv_count", rv_cyc.size(), 1);

`ifdef PU_ACCUM_CTRL_STATS_EN
    // 6: statistics counters
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    chk("t6_reset_grp", grp_count, 0);
    for (int g = 0; g < 3; g++) begin
      ovf_sel = (g == 1);
      send(4'(g + 1), 4'h0, 0, 1);
      wait_idle();
    end
    ovf_sel = 1'b0;
    chk("t6_grp", grp_count, 3);
    chk("t6_ovf", ovf_count, 1);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
